// File: rtl/rsa_pkg.sv
// Shared constants and FSM encoding for the RSA operand buffer.
package rsa_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_NUM_OPS    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ZFILL = 2'd2
    } state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rsa_operand_buffer_if.sv
// Operand word stream: valid/ready beats, least-significant word first.
interface rsa_operand_buffer_if
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/rsa_word_ram.sv
// Operand storage: one write port, two registered read-first read ports.
module rsa_word_ram #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_OPS    = 4,
    parameter int SELW       = 2,
    localparam int AW        = SELW + ADDR_WIDTH,
    localparam int WORDS     = NUM_OPS * (2 ** ADDR_WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_ok,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking reads see the pre-write word on a same-cycle collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (rd_ok) begin
            rdata1 <= mem[raddr1];
            rdata2 <= mem[raddr2];
        end else begin
            rdata1 <= '0;
            rdata2 <= '0;
        end
    end

endmodule

// File: rtl/rsa_operand_buffer.sv
// Multi-slot operand buffer: streams words into a slot, zero-pads the tail,
// and serves two registered read ports from the selected slot.
module rsa_operand_buffer
    import rsa_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_OPS    = DEF_NUM_OPS,
    localparam int SELW      = sel_width(NUM_OPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [SELW-1:0]       load_sel,
    input  logic                  load_abort,
    rsa_operand_buffer_if.slave   stream,
    output logic                  load_busy,
    output logic [NUM_OPS-1:0]    op_loaded,
    input  logic [SELW-1:0]       rd_sel,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    output logic [WIDTH-1:0]      dataoutl,
    output logic [WIDTH-1:0]      dataouth,
    output logic [ADDR_WIDTH:0]   op_len
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [SELW:0] NOPS = (SELW + 1)'(NUM_OPS);

    state_e                state;
    state_e                state_d;
    logic [SELW-1:0]       slot;
    logic [SELW-1:0]       slot_d;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_d;
    logic                  we;
    logic [WIDTH-1:0]      wdata;
    logic                  set_done;
    logic                  clr_loaded;
    logic                  rec_len;
    logic [ADDR_WIDTH:0]   len_val;
    logic [ADDR_WIDTH:0]   len_q [NUM_OPS];
    logic                  ld_ok;
    logic                  rd_ok;

    assign ld_ok = {1'b0, load_sel} < NOPS;
    assign rd_ok = {1'b0, rd_sel} < NOPS;

    assign stream.in_ready = (state == ST_LOAD);
    assign load_busy       = (state != ST_IDLE);

    always_comb begin
        state_d    = state;
        slot_d     = slot;
        cnt_d      = cnt;
        we         = 1'b0;
        wdata      = '0;
        set_done   = 1'b0;
        clr_loaded = 1'b0;
        rec_len    = 1'b0;
        len_val    = '0;
        unique case (state)
            ST_IDLE: begin
                if (load_start && ld_ok) begin
                    slot_d     = load_sel;
                    cnt_d      = '0;
                    clr_loaded = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_abort) begin
                    state_d = ST_IDLE;
                end else if (stream.in_valid) begin
                    we    = 1'b1;
                    wdata = stream.in_data;
                    if (cnt == LAST_W) begin
                        rec_len  = 1'b1;
                        len_val  = (ADDR_WIDTH + 1)'(DEPTH);
                        set_done = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt + ADDR_WIDTH'(1);
                        if (stream.in_last) begin
                            rec_len = 1'b1;
                            len_val = {1'b0, cnt} + (ADDR_WIDTH + 1)'(1);
                            state_d = ST_ZFILL;
                        end
                    end
                end
            end
            ST_ZFILL: begin
                // Pad the tail so the slot never exposes a stale operand.
                if (load_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    we = 1'b1;
                    if (cnt == LAST_W) begin
                        set_done = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            slot      <= '0;
            cnt       <= '0;
            op_loaded <= '0;
            op_len    <= '0;
            for (int i = 0; i < NUM_OPS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state <= state_d;
            slot  <= slot_d;
            cnt   <= cnt_d;
            if (clr_loaded) begin
                op_loaded[slot_d] <= 1'b0;
            end
            if (set_done) begin
                op_loaded[slot] <= 1'b1;
            end
            if (rec_len) begin
                len_q[slot] <= len_val;
            end
            op_len <= rd_ok ? len_q[rd_sel] : '0;
        end
    end

    rsa_word_ram #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_OPS    (NUM_OPS),
        .SELW       (SELW)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  ({slot, cnt}),
        .wdata  (wdata),
        .rd_ok  (rd_ok),
        .raddr1 ({rd_sel, addr1}),
        .raddr2 ({rd_sel, addr2}),
        .rdata1 (dataoutl),
        .rdata2 (dataouth)
    );

endmodule

// File: tb/tb_rsa_operand_buffer.sv
// Self-checking bench: behavioural slot model plus directed load scenarios.
module tb_rsa_operand_buffer;
    import rsa_pkg::*;

    localparam int W     = 32;
    localparam int AW    = 7;
    localparam int NO    = 4;
    localparam int SW    = 2;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic [SW-1:0] load_sel;
    logic          load_abort;
    logic          load_busy;
    logic [NO-1:0] op_loaded;
    logic [SW-1:0] rd_sel;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [W-1:0]  dataoutl;
    logic [W-1:0]  dataouth;
    logic [AW:0]   op_len;

    rsa_operand_buffer_if #(.WIDTH(W)) bus ();

    always #5 clk = ~clk;

    rsa_operand_buffer #(
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .NUM_OPS    (NO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_sel   (load_sel),
        .load_abort (load_abort),
        .stream     (bus),
        .load_busy  (load_busy),
        .op_loaded  (op_loaded),
        .rd_sel     (rd_sel),
        .addr1      (addr1),
        .addr2      (addr2),
        .dataoutl   (dataoutl),
        .dataouth   (dataouth),
        .op_len     (op_len)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit run    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Model: a slot is a list of received words; once it holds DEPTH
    // words it is complete. in_last switches to padding with zeros.
    logic [W-1:0]  mm [NO][DEPTH];
    bit            kn [NO][DEPTH];
    int            m_mode;
    int            m_slot;
    int            m_pos;
    logic [NO-1:0] m_loaded;
    int            m_len [NO];
    logic [W-1:0]  e_l;
    logic [W-1:0]  e_h;
    bit            e_lv;
    bit            e_hv;
    int            e_len;

    task automatic put(input logic [W-1:0] d);
        mm[m_slot][m_pos] = d;
        kn[m_slot][m_pos] = 1'b1;
        m_pos++;
        if (m_pos == DEPTH) begin
            m_loaded[m_slot] = 1'b1;
            m_mode = 0;
        end
    endtask

    initial begin
        foreach (kn[i, j]) kn[i][j] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0;
            m_pos = 0;
            m_loaded = '0;
            foreach (m_len[i]) m_len[i] = 0;
            e_l = '0; e_h = '0; e_lv = 1'b1; e_hv = 1'b1; e_len = 0;
        end else begin
            e_l   = mm[rd_sel][addr1];
            e_h   = mm[rd_sel][addr2];
            e_lv  = kn[rd_sel][addr1];
            e_hv  = kn[rd_sel][addr2];
            e_len = m_len[rd_sel];
            case (m_mode)
                0: if (load_start && int'(load_sel) < NO) begin
                    m_slot = int'(load_sel);
                    m_pos = 0;
                    m_loaded[m_slot] = 1'b0;
                    m_mode = 1;
                end
                1: if (load_abort) m_mode = 0;
                   else if (bus.in_valid) begin
                    put(bus.in_data);
                    if (m_mode == 0) m_len[m_slot] = DEPTH;
                    else if (bus.in_last) begin
                        m_len[m_slot] = m_pos;
                        m_mode = 2;
                    end
                end
                2: if (load_abort) m_mode = 0;
                   else put('0);
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n && run) begin
            chk("in_ready", 64'(bus.in_ready), 64'(m_mode == 1));
            chk("load_busy", 64'(load_busy), 64'(m_mode != 0));
            chk("op_loaded", 64'(op_loaded), 64'(m_loaded));
            chk("op_len", 64'(op_len), 64'(e_len));
            if (e_lv) chk("dataoutl", 64'(dataoutl), 64'(e_l));
            if (e_hv) chk("dataouth", 64'(dataouth), 64'(e_h));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [SW-1:0] s);
        load_start = 1'b1;
        load_sel = s;
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_last = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_idle(output int n, output bit rdy);
        n = 0;
        rdy = 1'b0;
        while (load_busy && n < 400) begin
            if (bus.in_ready) rdy = 1'b1;
            tick();
            n++;
        end
        chk("idle_bound", 64'(load_busy), 64'(0));
    endtask

    int n;
    bit rdy;

    initial begin
        rst_n = 1'b1;
        load_start = 1'b0; load_sel = '0; load_abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        rd_sel = '0; addr1 = '0; addr2 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(load_busy), 64'(0));
        chk("rst_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_loaded", 64'(op_loaded), 64'(0));
        chk("rst_len", 64'(op_len), 64'(0));
        chk("rst_dl", 64'(dataoutl), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run = 1'b1;

        // Full load into slot 1, no in_last.
        start(2'd1);
        for (int i = 0; i < DEPTH; i++) beat(W'(i), 1'b0);
        chk("full_busy", 64'(load_busy), 64'(0));
        chk("full_loaded", 64'(op_loaded), 64'(4'b0010));
        rd_sel = 2'd1; addr1 = 7'd0; addr2 = 7'd127;
        tick();
        chk("full_w0", 64'(dataoutl), 64'(0));
        chk("full_w127", 64'(dataouth), 64'(127));
        chk("full_len", 64'(op_len), 64'(128));

        // Short load into slot 0 with zero padding.
        start(2'd0);
        beat(32'hA, 1'b0);
        beat(32'hB, 1'b0);
        beat(32'hC, 1'b1);
        wait_idle(n, rdy);
        chk("zfill_cycles", 64'(n), 64'(125));
        chk("zfill_ready", 64'(rdy), 64'(0));
        chk("short_loaded", 64'(op_loaded[0]), 64'(1));
        rd_sel = 2'd0; addr1 = 7'd3; addr2 = 7'd2;
        tick();
        chk("short_w3", 64'(dataoutl), 64'(0));
        chk("short_w2", 64'(dataouth), 64'(32'hC));
        chk("short_len", 64'(op_len), 64'(3));
        addr1 = 7'd127;
        tick();
        chk("short_w127", 64'(dataoutl), 64'(0));

        // Backpressure into slot 3: valid every other cycle.
        start(2'd3);
        for (int k = 0; k < 6; k++) begin
            beat(32'h100 + W'(k), k == 5);
            bus.in_data = 32'hDEAD;
            if (k != 5) tick();
        end
        wait_idle(n, rdy);
        rd_sel = 2'd3; addr1 = 7'd4; addr2 = 7'd5;
        tick();
        chk("bp_w4", 64'(dataoutl), 64'(32'h104));
        chk("bp_w5", 64'(dataouth), 64'(32'h105));
        chk("bp_len", 64'(op_len), 64'(6));

        // Abort in slot 2 after 10 beats; slot preloaded so word 10 is 0.
        start(2'd2);
        beat(32'h2FF, 1'b1);
        wait_idle(n, rdy);
        start(2'd2);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                load_start = 1'b1;
                load_sel = 2'd3;
            end
            beat(32'h200 + W'(k), 1'b0);
            load_start = 1'b0;
        end
        bus.in_valid = 1'b1; bus.in_data = 32'hBAD;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0; bus.in_valid = 1'b0;
        chk("abort_busy", 64'(load_busy), 64'(0));
        chk("abort_loaded2", 64'(op_loaded[2]), 64'(0));
        chk("abort_loaded3", 64'(op_loaded[3]), 64'(1));
        rd_sel = 2'd2; addr1 = 7'd9; addr2 = 7'd10;
        tick();
        chk("abort_w9", 64'(dataoutl), 64'(32'h209));
        chk("abort_w10", 64'(dataouth), 64'(0));

        // Read-first collision on slot 0 word 5.
        rd_sel = 2'd0; addr1 = 7'd5; addr2 = 7'd2;
        start(2'd0);
        for (int k = 0; k < 5; k++) beat(32'h50 + W'(k), 1'b0);
        beat(32'h55, 1'b0);
        chk("rf_old", 64'(dataoutl), 64'(0));
        tick();
        chk("rf_new", 64'(dataoutl), 64'(32'h55));
        chk("rf_w2", 64'(dataouth), 64'(32'h52));
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;

        // Asynchronous reset in the middle of zero padding.
        rd_sel = 2'd1; addr1 = 7'd100; addr2 = 7'd101;
        start(2'd3);
        beat(32'h3A, 1'b1);
        tick();
        tick();
        chk("zf_busy_pre", 64'(load_busy), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("ar_busy", 64'(load_busy), 64'(0));
        chk("ar_ready", 64'(bus.in_ready), 64'(0));
        chk("ar_loaded", 64'(op_loaded), 64'(0));
        chk("ar_len", 64'(op_len), 64'(0));
        chk("ar_dl", 64'(dataoutl), 64'(0));
        chk("ar_dh", 64'(dataouth), 64'(0));
        #1 rst_n = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rsa_operand_buffer.md
RSA_OPERAND_BUFFER -- requirements
Module: rsa_operand_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, word address width; DEPTH = 2**ADDR_WIDTH words per slot.
REQ-003 SHALL have parameter NUM_OPS, default 4, number of operand slots; SELW = max(1, clog2(NUM_OPS)).
REQ-004 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: load_start  input  1  request a load into slot load_sel.
REQ-007 SHALL have port: load_sel  input  SELW  target slot for load_start.
REQ-008 SHALL have port: load_abort  input  1  cancel an in-progress load.
REQ-009 SHALL have port: in_valid  input  1  in_data/in_last valid.
REQ-010 SHALL have port: in_ready  output  1  buffer accepts a beat.
REQ-011 SHALL have port: in_data  input  WIDTH  operand word, least-significant word first.
REQ-012 SHALL have port: in_last  input  1  final word of operand.
REQ-013 SHALL have port: load_busy  output  1  high outside IDLE.
REQ-014 SHALL have port: op_loaded  output  NUM_OPS  per-slot complete flag.
REQ-015 SHALL have port: rd_sel  input  SELW  slot read by both read ports.
REQ-016 SHALL have port: addr1, addr2  input  ADDR_WIDTH each  read addresses.
REQ-017 SHALL have port: dataoutl, dataouth  output  WIDTH each  registered words at addr1, addr2.
REQ-018 SHALL have port: op_len  output  ADDR_WIDTH+1  words received for slot rd_sel (registered).

Function
REQ-019 FSM states SHALL be IDLE, LOAD, ZFILL; in_ready = (state==LOAD); load_busy = (state!=IDLE).
REQ-020 In IDLE, load_start with load_sel < NUM_OPS SHALL latch slot, clear op_loaded[slot], clear word counter cnt, go to LOAD next cycle; load_sel >= NUM_OPS SHALL be ignored.
REQ-021 load_start outside IDLE SHALL be ignored.
REQ-022 In LOAD, each cycle with in_valid & in_ready SHALL write in_data to mem[slot][cnt] and increment cnt.
REQ-023 Accepted beat with in_last and cnt < DEPTH-1 SHALL record len = cnt+1 and go to ZFILL.
REQ-024 Accepted beat at cnt == DEPTH-1 (in_last or not) SHALL record len = DEPTH, set op_loaded[slot], go to IDLE; counter SHALL NOT wrap.
REQ-025 ZFILL SHALL write zero to mem[slot][cnt] one word per cycle up to DEPTH-1, then set op_loaded[slot] and go to IDLE in the cycle after the DEPTH-1 write.
REQ-026 load_abort in LOAD or ZFILL SHALL return to IDLE next cycle with op_loaded[slot] left 0; beat coincident with abort SHALL NOT be written; abort in IDLE ignored.
REQ-027 Read ports SHALL have 1-cycle latency: dataoutl <= mem[rd_sel][addr1], dataouth <= mem[rd_sel][addr2] every cycle.
REQ-028 Read and write to same word in same cycle SHALL return old data (read-first).
REQ-029 Reads of a slot mid-load SHALL return current memory contents; op_loaded gates validity, not the read path.
REQ-030 rd_sel >= NUM_OPS SHALL return zero on both data outputs and op_len.

Reset
REQ-031 rst_n low SHALL asynchronously force state IDLE, cnt 0, op_loaded 0, all len 0, dataoutl/dataouth/op_len 0, in_ready 0, load_busy 0.
REQ-032 Memory contents SHALL NOT be reset; reset mid-load SHALL leave that slot with op_loaded 0.

Structure
REQ-033 Shared package rsa_pkg SHALL hold default WIDTH/ADDR_WIDTH/NUM_OPS constants and the FSM state enum.
REQ-034 Storage SHALL be a sub-module rsa_word_ram: one write port, two registered read ports, NUM_OPS*DEPTH words.

Verification
REQ-035 Full load: slot 1, 128 beats data=i, no in_last -> op_loaded=4'b0010 after last beat, op_len=128, addr1=0/addr2=127 give 0/127 one cycle later.
REQ-036 Short load: slot 0, 3 beats 0xA,0xB,0xC with in_last on third -> in_ready 0 for 125 ZFILL cycles, then op_loaded[0]=1, op_len=3, word 3..127 read 0.
REQ-037 Backpressure/handshake: in_valid toggled every other cycle during load -> only valid&ready beats written, contents match beat order.
REQ-038 Abort: load slot 2, abort after 10 beats -> IDLE next cycle, op_loaded[2]=0, load_start during LOAD ignored.
REQ-039 Read-first: read addr 5 of slot 0 while beat 5 written -> dataoutl shows prior value, new value next read.
REQ-040 Async reset mid-ZFILL -> all outputs 0 immediately, load_busy 0, op_loaded 0.
